// File: rtl/uart_disp_pkg.sv
// Shared types and constants for the UART-to-7-segment display scheduler.
package uart_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } disp_state_e;

  // Dwell and blank times for a 25 MHz core clock.
  localparam int unsigned HOLD_CLKS_25M = 25_000_000;
  localparam int unsigned GAP_CLKS_25M  = 2_500_000;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 2 * NIB_W;

endpackage

// File: rtl/uart_disp_fifo.sv
// Small synchronous byte queue: registered count, head visible combinationally,
// a push into a full queue is accepted only when a pop frees the slot that same cycle.
module uart_disp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !flush_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !flush_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count guards every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_disp_scheduler.sv
// Paces received UART bytes onto two 7-segment digits, each byte held HOLD_CLKS cycles.
// Define UART_DISP_GAP_EN to blank the digits for GAP_CLKS cycles between queued bytes.
module uart_disp_scheduler
  import uart_disp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOLD_CLKS  = HOLD_CLKS_25M,
  parameter int unsigned GAP_CLKS   = GAP_CLKS_25M
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_RX_DV,
  input  logic [BYTE_W-1:0]             i_RX_Byte,
  input  logic                          i_Clear,
  output logic [NIB_W-1:0]              o_Nibble_Hi,
  output logic [NIB_W-1:0]              o_Nibble_Lo,
  output logic                          o_Display_En,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Overflow
);

  localparam int unsigned CNT_MAX = (GAP_CLKS > HOLD_CLKS) ? GAP_CLKS : HOLD_CLKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  disp_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] disp_q, disp_d;
  logic              en_q, en_d;
  logic              ovf_q, ovf_d;
  logic              pop;
  logic              hold_done;
  logic [BYTE_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;

  uart_disp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk_i      (i_Clk),
    .rst_ni     (i_Rst_L),
    .push_i     (i_RX_DV),
    .push_dat_i (i_RX_Byte),
    .pop_i      (pop),
    .flush_i    (i_Clear),
    .head_dat_o (fifo_head),
    .count_o    (o_Fifo_Count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign hold_done = (cnt_q == CNT_W'(HOLD_CLKS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    en_d    = en_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;
    if (i_Clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      en_d    = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            disp_d  = fifo_head;
            en_d    = 1'b1;
            cnt_d   = '0;
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (hold_done) begin
            cnt_d = '0;
            if (fifo_empty) begin
              state_d = IDLE;
            end else begin
`ifdef UART_DISP_GAP_EN
              state_d = GAP;
              en_d    = 1'b0;
`else
              pop     = 1'b1;
              disp_d  = fifo_head;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_DISP_GAP_EN
        // Pop is deferred to the gap exit so the blanking sits between bytes.
        GAP: begin
          if (cnt_q == CNT_W'(GAP_CLKS - 1)) begin
            pop     = 1'b1;
            disp_d  = fifo_head;
            en_d    = 1'b1;
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
      if (i_RX_DV && fifo_full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      disp_q  <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_Nibble_Hi  = disp_q[BYTE_W-1 -: NIB_W];
  assign o_Nibble_Lo  = disp_q[NIB_W-1:0];
  assign o_Display_En = en_q;
  assign o_Overflow   = ovf_q;

endmodule

// File: tb/tb_uart_disp_scheduler.sv
// Bench for uart_disp_scheduler: cycle table, hand sequences and a display-order scoreboard.
module tb_uart_disp_scheduler;

  localparam int DEPTH = 4;
  localparam int HOLD  = 8;
  localparam int GAPC  = 3;
`ifdef UART_DISP_GAP_EN
  localparam int G = GAPC;
`else
  localparam int G = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       clr;
  logic [3:0] hi, lo;
  logic       en;
  logic [2:0] cnt;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  uart_disp_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .HOLD_CLKS  (HOLD),
    .GAP_CLKS   (GAPC)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_RX_DV      (rx_dv),
    .i_RX_Byte    (rx_byte),
    .i_Clear      (clr),
    .o_Nibble_Hi  (hi),
    .o_Nibble_Lo  (lo),
    .o_Display_En (en),
    .o_Fifo_Count (cnt),
    .o_Overflow   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A byte "appears" when the digits turn on or change value while on.
  logic       prev_en = 1'b0;
  logic [7:0] prev_d  = 8'h00;
  always @(negedge clk) begin
    if (rst_n && en && (!prev_en || {hi, lo} != prev_d)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got %0h, expected no new byte", {hi, lo});
      end else begin
        chk("sb_order", {24'h0, hi, lo}, {24'h0, exp_q.pop_front()});
      end
    end
    prev_en = en;
    prev_d  = {hi, lo};
  end

  typedef struct {
    logic       dv;
    logic [7:0] b;
    logic       clr;
    logic       sb;
    logic       en;
    logic       chk_d;
    logic [7:0] d;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(logic dv, logic [7:0] b, logic c, logic sb, logic e,
                              logic cd, logic [7:0] d, logic [2:0] n, logic o);
    vec_t v;
    v.dv = dv; v.b = b; v.clr = c; v.sb = sb; v.en = e;
    v.chk_d = cd; v.d = d; v.cnt = n; v.ovf = o;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int lows;
    logic       e;
    logic [7:0] d;
    logic [2:0] c;

    // Single byte 0xA5, then a 6-strobe burst into an idle queue, then clear with a strobe.
    tbl[0] = mk(0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0);
    tbl[1] = mk(1, 8'hA5, 0, 1, 0, 1, 8'h00, 0, 0);
    tbl[2] = mk(0, 8'h00, 0, 0, 0, 1, 8'h00, 1, 0);
    for (int i = 3; i <= 12; i++) tbl[i] = mk(0, 8'h00, 0, 0, 1, 1, 8'hA5, 0, 0);
    tbl[13] = mk(1, 8'hB0, 0, 1, 1, 1, 8'hA5, 0, 0);
    tbl[14] = mk(1, 8'hB1, 0, 1, 1, 1, 8'hA5, 1, 0);
    tbl[15] = mk(1, 8'hB2, 0, 1, 1, 1, 8'hB0, 1, 0);
    tbl[16] = mk(1, 8'hB3, 0, 1, 1, 1, 8'hB0, 2, 0);
    tbl[17] = mk(1, 8'hB4, 0, 1, 1, 1, 8'hB0, 3, 0);
    tbl[18] = mk(1, 8'hB5, 0, 0, 1, 1, 8'hB0, 4, 0);
    tbl[19] = mk(0, 8'h00, 0, 0, 1, 1, 8'hB0, 4, 1);
    tbl[20] = mk(1, 8'hEE, 1, 0, 1, 1, 8'hB0, 4, 1);
    for (int i = 21; i <= 25; i++) tbl[i] = mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);

    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", en, 0);
    chk("rst_nib", {hi, lo}, 8'h00);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      rx_dv = tbl[i].dv; rx_byte = tbl[i].b; clr = tbl[i].clr;
      if (tbl[i].clr) exp_q.delete();
      if (tbl[i].sb) exp_q.push_back(tbl[i].b);
      chk($sformatf("tbl%0d_en", i), en, tbl[i].en);
      if (tbl[i].en || tbl[i].chk_d) chk($sformatf("tbl%0d_nib", i), {hi, lo}, tbl[i].d);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
      step();
    end
    rx_dv = 1'b0; clr = 1'b0;

    // Back-to-back 0x12, 0x34, 0x56.
    rx_dv = 1'b1; rx_byte = 8'h12; exp_q.push_back(8'h12);
    chk("b2b_q0_cnt", cnt, 0);
    step();
    rx_byte = 8'h34; exp_q.push_back(8'h34);
    chk("b2b_q1_cnt", cnt, 1);
    step();
    rx_byte = 8'h56; exp_q.push_back(8'h56);
    chk("b2b_q2_cnt", cnt, 1);
    chk("b2b_q2_en", en, 1);
    chk("b2b_q2_nib", {hi, lo}, 8'h12);
    step();
    rx_dv = 1'b0;
    for (int k = 3; k <= 26 + 2 * G; k++) begin
      d = 8'h00;
      if (k < 10)               begin e = 1; d = 8'h12; c = 2; end
      else if (k < 10 + G)      begin e = 0; c = 2; end
      else if (k < 18 + G)      begin e = 1; d = 8'h34; c = 1; end
      else if (k < 18 + 2 * G)  begin e = 0; c = 1; end
      else                      begin e = 1; d = 8'h56; c = 0; end
      chk($sformatf("b2b_k%0d_en", k), en, e);
      if (e) chk($sformatf("b2b_k%0d_nib", k), {hi, lo}, d);
      chk($sformatf("b2b_k%0d_cnt", k), cnt, c);
      step();
    end

    // Fill the queue, then strobe 0x77 on the very edge that pops the head.
    for (int k = 0; k <= 9 + G; k++) begin
      rx_dv   = (k < 5) || (k == 9 + G);
      rx_byte = (k < 5) ? 8'(8'hC0 + k) : 8'h77;
      if (rx_dv) exp_q.push_back(rx_byte);
      if (k == 5) chk("full_cnt", cnt, 4);
      if (k == 9 + G) begin
        chk("fullpop_cnt_before", cnt, 4);
        chk("fullpop_ovf_before", ovf, 0);
      end
      step();
    end
    rx_dv = 1'b0;
    chk("fullpop_cnt_after", cnt, 4);
    chk("fullpop_ovf_after", ovf, 0);
    chk("fullpop_en", en, 1);
    chk("fullpop_nib", {hi, lo}, 8'hC1);
    repeat (4 * (8 + G) + 10) step();
    chk("drain_last_nib", {hi, lo}, 8'h77);
    chk("drain_en", en, 1);
    chk("drain_cnt", cnt, 0);
    chk("drain_ovf", ovf, 0);
    chk("drain_sb_empty", exp_q.size(), 0);

    // Repeated identical byte: blank window only when the gap feature is built in.
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("rep_clr_en", en, 0);
    chk("rep_clr_cnt", cnt, 0);
    rx_dv = 1'b1; rx_byte = 8'h11; exp_q.push_back(8'h11);
    step();
    if (G > 0) exp_q.push_back(8'h11);
    step();
    rx_dv = 1'b0;
    lows = 0;
    for (int k = 2; k <= 20 + G; k++) begin
      e = !(k >= 10 && k < 10 + G);
      if (!en && k <= 17 + G) lows++;
      chk($sformatf("rep_k%0d_en", k), en, e);
      if (e) chk($sformatf("rep_k%0d_nib", k), {hi, lo}, 8'h11);
      step();
    end
    chk("rep_blank_cycles", lows, G);

    // Asynchronous reset mid-dwell with a byte still queued.
    rx_dv = 1'b1; rx_byte = 8'h5A; exp_q.push_back(8'h5A);
    step();
    rx_byte = 8'hC3; exp_q.push_back(8'hC3);
    step();
    rx_dv = 1'b0;
    repeat (3) step();
    chk("rst_mid_en_before", en, 1);
    chk("rst_mid_nib_before", {hi, lo}, 8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_mid_en", en, 0);
    chk("rst_mid_nib", {hi, lo}, 8'h00);
    chk("rst_mid_cnt", cnt, 0);
    chk("rst_mid_ovf", ovf, 0);
    #4;
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("post_rst%0d_en", k), en, 0);
      chk($sformatf("post_rst%0d_nib", k), {hi, lo}, 8'h00);
      chk($sformatf("post_rst%0d_cnt", k), cnt, 0);
      step();
    end
    chk("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
